sram_axi_bridge: RTL and testbench
==================================

Name: sram_axi_bridge

Overview:
- Sits directly downstream of the CPU core and consumes its two SRAM-like request interfaces (inst and data), which use req/addr_ok/data_ok handshakes.
- Converts them to one AXI3 master port. The CPU top instantiates it between the core and the AXI interconnect.
- At most one read and one write transaction are in flight at a time.
- Responses to each core-side master are returned in request order.

Parameters:
- ID_W, 4, width of AXI ID fields.
- INST_ID, 0, arid used for inst reads.
- DATA_ID, 1, arid/awid/wid used for data accesses.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- inst_sram_req/wr/size/wstrb/addr/wdata  in  1/1/2/4/32/32  inst request; wr, wstrb and wdata are ignored (inst side is read-only)
- inst_sram_addr_ok  out  1  inst request accepted this cycle
- inst_sram_data_ok  out  1  inst read data valid this cycle
- inst_sram_rdata  out  32  inst read data
- data_sram_req/wr/size/wstrb/addr/wdata  in  1/1/2/4/32/32  data request
- data_sram_addr_ok/data_ok  out  1/1  data handshake
- data_sram_rdata  out  32  data read data
- arid/araddr/arsize/arvalid  out  ID_W/32/3/1  AXI read address
- arready  in  1
- rid/rdata/rresp/rlast/rvalid  in  ID_W/32/2/1/1  AXI read data
- rready  out  1
- awid/awaddr/awsize/awvalid  out  ID_W/32/3/1  AXI write address
- awready  in  1
- wid/wdata/wstrb/wlast/wvalid  out  ID_W/32/4/1/1  AXI write data
- wready  in  1
- bid/bresp/bvalid  in  ID_W/2/1
- bready  out  1
- arlen/awlen, arburst/awburst, arlock/awlock, arcache/awcache, arprot/awprot  out  8/2/2/4/3  constants 0, 2'b01, 0, 0, 0

Behaviour:
- Read FSM: R_IDLE -> R_AR on accept; R_AR -> R_WAIT on arvalid&arready; R_WAIT -> R_IDLE on rvalid.
  - Registered on accept: addr, arsize={1'b0,size}, owner bit (inst/data).
  - arvalid=1 only in R_AR; rready=1 only in R_WAIT.
  - In R_WAIT with rvalid: the owner's data_ok pulses for 1 cycle and rdata=rdata.
  - rresp, rlast and rid are ignored; the owner register steers the response.
- Write FSM: W_IDLE -> W_SEND on accept; W_SEND -> W_B when both aw_done and w_done; W_B -> W_IDLE on bvalid.
  - Registered on accept: awaddr, awsize, wdata, wstrb.
  - awvalid and wvalid are both raised the cycle after accept. Each drops independently after its own handshake; aw_done/w_done latch.
  - wlast=1 always. bready=1 only in W_B.
  - On bvalid in W_B: data_sram_data_ok pulses for 1 cycle. bresp is ignored.
- Acceptance (addr_ok is combinational, same cycle as req):
  - data_busy = read FSM owned by data and not idle, OR write FSM not idle.
  - Data read: data_sram_req & ~wr & R_IDLE & ~data_busy & ~hazard.
  - Data write: data_sram_req & wr & W_IDLE & ~data_busy & ~(read busy with addr[31:2] equal).
  - Inst read: inst_sram_req & R_IDLE & ~(data read accepted this cycle) & ~hazard.
  - hazard = write FSM not idle and awaddr[31:2] == request addr[31:2].
- Priority: data read beats inst read in the same cycle. An inst read and a data write may be accepted in the same cycle.
- Latency: accept at T; arvalid/awvalid at T+1 at the earliest; data_ok at the earliest in the cycle rvalid/bvalid is first sampled in R_WAIT/W_B. Best case read: T+2.
- Ordering: data-side requests are serialized (no new data accept while data_busy), so data responses are always in order.
- Reset: asynchronous, active-low.
  - All FSMs go to IDLE; arvalid, awvalid, wvalid, rready, bready, addr_ok and data_ok are 0.
  - rdata outputs and address/data registers are 0.
  - addr_ok is forced to 0 while resetn=0.
  - A transaction in flight is dropped; no data_ok is emitted for it after release.

Test Plan:
- Inst read 0x1c000000, arready immediate, rvalid 2 cycles later with 0x02800413 -> arid=0, arsize=3'b010; inst_sram_data_ok=1 for exactly 1 cycle with rdata=0x02800413.
- Inst and data read requested in the same cycle (0x1c000010 / 0x1c008000) -> data_addr_ok=1, inst_addr_ok=0; arid=1 first; inst is accepted in the cycle after data_sram_data_ok.
- Data write 0x1c008000, wdata 0x12345678, wstrb 0xF; awready delayed 3 cycles, wready immediate -> wvalid high 1 cycle, awvalid high 4 cycles; bready only afterwards; data_ok in the bvalid cycle.
- Write to 0x00000100 outstanding -> inst read 0x00000100 sees addr_ok=0 until the cycle after bvalid; inst read 0x00000104 is accepted immediately.
- Data read request while a data write awaits B -> data_addr_ok=0 until after the write's data_ok; no reordering.
- resetn=0 during R_WAIT -> arvalid/rready drop immediately; after release, a subsequent rvalid pulse produces no data_ok.

Source files
------------

// File: rtl/sram_axi_bridge_if.sv
// AXI3 master-port bundle between the SRAM-to-AXI bridge and the interconnect.
// Every channel follows one rule: a beat transfers on a rising edge where valid
// and ready are both high, and valid never waits on ready before asserting.
interface sram_axi_bridge_if #(
   parameter int ID_W = 4
);
   logic [ID_W-1:0] arid;
   logic [31:0]     araddr;
   logic [7:0]      arlen;
   logic [2:0]      arsize;
   logic [1:0]      arburst;
   logic [1:0]      arlock;
   logic [3:0]      arcache;
   logic [2:0]      arprot;
   logic            arvalid;
   logic            arready;

   logic [ID_W-1:0] rid;
   logic [31:0]     rdata;
   logic [1:0]      rresp;
   logic            rlast;
   logic            rvalid;
   logic            rready;

   logic [ID_W-1:0] awid;
   logic [31:0]     awaddr;
   logic [7:0]      awlen;
   logic [2:0]      awsize;
   logic [1:0]      awburst;
   logic [1:0]      awlock;
   logic [3:0]      awcache;
   logic [2:0]      awprot;
   logic            awvalid;
   logic            awready;

   logic [ID_W-1:0] wid;
   logic [31:0]     wdata;
   logic [3:0]      wstrb;
   logic            wlast;
   logic            wvalid;
   logic            wready;

   logic [ID_W-1:0] bid;
   logic [1:0]      bresp;
   logic            bvalid;
   logic            bready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready,
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready,
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready
   );
endinterface

// File: rtl/sram_axi_bridge.sv
// Bridges the core's inst/data SRAM-like ports onto one AXI3 master port with
// one read and one write outstanding; FSM states are exported for observation.
module sram_axi_bridge #(
   parameter int ID_W    = 4,
   parameter int INST_ID = 0,
   parameter int DATA_ID = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_sram_req,
   input  logic        inst_sram_wr,
   input  logic [1:0]  inst_sram_size,
   input  logic [3:0]  inst_sram_wstrb,
   input  logic [31:0] inst_sram_addr,
   input  logic [31:0] inst_sram_wdata,
   output logic        inst_sram_addr_ok,
   output logic        inst_sram_data_ok,
   output logic [31:0] inst_sram_rdata,
   input  logic        data_sram_req,
   input  logic        data_sram_wr,
   input  logic [1:0]  data_sram_size,
   input  logic [3:0]  data_sram_wstrb,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic        data_sram_addr_ok,
   output logic        data_sram_data_ok,
   output logic [31:0] data_sram_rdata,
   sram_axi_bridge_if.master axi,
   output logic [1:0]  r_state_dbg,
   output logic [1:0]  w_state_dbg
);
   typedef enum logic [1:0] {R_IDLE = 2'd0, R_AR = 2'd1, R_WAIT = 2'd2} r_state_t;
   typedef enum logic [1:0] {W_IDLE = 2'd0, W_SEND = 2'd1, W_B = 2'd2} w_state_t;

   r_state_t    r_state, r_next;
   w_state_t    w_state, w_next;
   logic [31:0] rd_addr, wr_addr, wr_data;
   logic [2:0]  rd_size, wr_size;
   logic [3:0]  wr_strb;
   logic        rd_owner;
   logic        aw_done, w_done;
   logic        r_busy, w_busy, data_busy, haz_d, haz_i;
   logic        d_rd_acc, d_wr_acc, i_acc;
   logic        aw_valid, w_valid, aw_fire, w_fire, r_fire, b_fire;

   // rd_owner is 1 when the in-flight read belongs to the data port.
   assign r_busy    = (r_state != R_IDLE);
   assign w_busy    = (w_state != W_IDLE);
   assign data_busy = (r_busy && rd_owner) || w_busy;
   assign haz_d     = w_busy && (wr_addr[31:2] == data_sram_addr[31:2]);
   assign haz_i     = w_busy && (wr_addr[31:2] == inst_sram_addr[31:2]);

   assign d_rd_acc = resetn && data_sram_req && !data_sram_wr && !r_busy && !data_busy && !haz_d;
   assign d_wr_acc = resetn && data_sram_req && data_sram_wr && !w_busy && !data_busy
                     && !(r_busy && (rd_addr[31:2] == data_sram_addr[31:2]));
   assign i_acc    = resetn && inst_sram_req && !r_busy && !d_rd_acc && !haz_i;

   assign aw_valid = (w_state == W_SEND) && !aw_done;
   assign w_valid  = (w_state == W_SEND) && !w_done;
   assign aw_fire  = aw_valid && axi.awready;
   assign w_fire   = w_valid && axi.wready;
   assign r_fire   = (r_state == R_WAIT) && axi.rvalid;
   assign b_fire   = (w_state == W_B) && axi.bvalid;

   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (d_rd_acc || i_acc) r_next = R_AR;
         R_AR:    if (axi.arready) r_next = R_WAIT;
         R_WAIT:  if (axi.rvalid) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   always_comb begin
      w_next = w_state;
      case (w_state)
         W_IDLE:  if (d_wr_acc) w_next = W_SEND;
         W_SEND:  if ((aw_done || aw_fire) && (w_done || w_fire)) w_next = W_B;
         W_B:     if (axi.bvalid) w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state  <= R_IDLE;
         w_state  <= W_IDLE;
         rd_addr  <= '0;
         rd_size  <= '0;
         rd_owner <= 1'b0;
         wr_addr  <= '0;
         wr_size  <= '0;
         wr_data  <= '0;
         wr_strb  <= '0;
         aw_done  <= 1'b0;
         w_done   <= 1'b0;
      end else begin
         r_state <= r_next;
         w_state <= w_next;
         if (d_rd_acc) begin
            rd_addr  <= data_sram_addr;
            rd_size  <= {1'b0, data_sram_size};
            rd_owner <= 1'b1;
         end else if (i_acc) begin
            rd_addr  <= inst_sram_addr;
            rd_size  <= {1'b0, inst_sram_size};
            rd_owner <= 1'b0;
         end
         if (d_wr_acc) begin
            wr_addr <= data_sram_addr;
            wr_size <= {1'b0, data_sram_size};
            wr_data <= data_sram_wdata;
            wr_strb <= data_sram_wstrb;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end else begin
            if (aw_fire) aw_done <= 1'b1;
            if (w_fire)  w_done  <= 1'b1;
         end
      end
   end

   assign inst_sram_addr_ok = i_acc;
   assign data_sram_addr_ok = d_rd_acc || d_wr_acc;
   assign inst_sram_data_ok = r_fire && !rd_owner;
   assign data_sram_data_ok = (r_fire && rd_owner) || b_fire;
   assign inst_sram_rdata   = (r_fire && !rd_owner) ? axi.rdata : 32'h0;
   assign data_sram_rdata   = (r_fire && rd_owner) ? axi.rdata : 32'h0;

   assign axi.arid    = rd_owner ? ID_W'(DATA_ID) : ID_W'(INST_ID);
   assign axi.araddr  = rd_addr;
   assign axi.arsize  = rd_size;
   assign axi.arlen   = 8'd0;
   assign axi.arburst = 2'b01;
   assign axi.arlock  = 2'b00;
   assign axi.arcache = 4'b0000;
   assign axi.arprot  = 3'b000;
   assign axi.arvalid = (r_state == R_AR);
   assign axi.rready  = (r_state == R_WAIT);

   assign axi.awid    = ID_W'(DATA_ID);
   assign axi.awaddr  = wr_addr;
   assign axi.awsize  = wr_size;
   assign axi.awlen   = 8'd0;
   assign axi.awburst = 2'b01;
   assign axi.awlock  = 2'b00;
   assign axi.awcache = 4'b0000;
   assign axi.awprot  = 3'b000;
   assign axi.awvalid = aw_valid;
   assign axi.wid     = ID_W'(DATA_ID);
   assign axi.wdata   = wr_data;
   assign axi.wstrb   = wr_strb;
   assign axi.wlast   = 1'b1;
   assign axi.wvalid  = w_valid;
   assign axi.bready  = (w_state == W_B);

   assign r_state_dbg = r_state;
   assign w_state_dbg = w_state;

   // Response IDs/status and the inst write fields carry no meaning for this bridge.
   logic unused_bits;
   assign unused_bits = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                          axi.rid, axi.rresp, axi.rlast, axi.bid, axi.bresp};
endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: the bench plays the AXI slave by hand,
// one task per scenario, each cycle driven and sampled just after the falling edge.
module tb_sram_axi_bridge;
  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [1:0]  r_state_dbg, w_state_dbg;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  sram_axi_bridge_if #(.ID_W(4)) bus ();

  sram_axi_bridge #(.ID_W(4), .INST_ID(0), .DATA_ID(1)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .axi(bus),
    .r_state_dbg(r_state_dbg), .w_state_dbg(w_state_dbg)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish before 200000");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic init_inputs();
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'd2; inst_sram_wstrb = 0;
    inst_sram_addr = 0; inst_sram_wdata = 0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd2; data_sram_wstrb = 0;
    data_sram_addr = 0; data_sram_wdata = 0;
    bus.arready = 0; bus.rid = 0; bus.rdata = 0; bus.rresp = 0; bus.rlast = 1; bus.rvalid = 0;
    bus.awready = 0; bus.wready = 0; bus.bid = 0; bus.bresp = 0; bus.bvalid = 0;
  endtask

  task automatic data_write(input logic [31:0] a, input logic [31:0] d);
    data_sram_req = 1; data_sram_wr = 1; data_sram_addr = a;
    data_sram_wdata = d; data_sram_wstrb = 4'hF; data_sram_size = 2'd2;
  endtask

  task automatic test_reset();
    resetn = 0;
    inst_sram_req = 1; inst_sram_addr = 32'h1000;
    data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h2000;
    cyc(); #1;
    vec_cnt++; if (inst_sram_addr_ok !== 1'b0) begin err_cnt++; $display("FAIL rst_inst_addr_ok got=%0b exp=0", inst_sram_addr_ok); end
    vec_cnt++; if (data_sram_addr_ok !== 1'b0) begin err_cnt++; $display("FAIL rst_data_addr_ok got=%0b exp=0", data_sram_addr_ok); end
    vec_cnt++; if ({bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready} !== 5'b0) begin err_cnt++; $display("FAIL rst_axi_valids got=%b exp=00000", {bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready}); end
    vec_cnt++; if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b00) begin err_cnt++; $display("FAIL rst_data_ok got=%b exp=00", {inst_sram_data_ok, data_sram_data_ok}); end
    vec_cnt++; if ({inst_sram_rdata, data_sram_rdata} !== 64'h0) begin err_cnt++; $display("FAIL rst_rdata got=%h exp=0", {inst_sram_rdata, data_sram_rdata}); end
    vec_cnt++; if ({bus.araddr, bus.awaddr, bus.wdata} !== 96'h0) begin err_cnt++; $display("FAIL rst_regs got=%h exp=0", {bus.araddr, bus.awaddr, bus.wdata}); end
    vec_cnt++; if ({r_state_dbg, w_state_dbg} !== 4'b0) begin err_cnt++; $display("FAIL rst_states got=%b exp=0000", {r_state_dbg, w_state_dbg}); end
    inst_sram_req = 0; data_sram_req = 0;
    cyc(); resetn = 1;
    cyc();
  endtask

  task automatic test_inst_read();
    cyc(); inst_sram_req = 1; inst_sram_addr = 32'h1c000000; inst_sram_size = 2'd2; #1;
    vec_cnt++; if (inst_sram_addr_ok !== 1'b1) begin err_cnt++; $display("FAIL ir_addr_ok got=%0b exp=1", inst_sram_addr_ok); end
    cyc(); inst_sram_req = 0; bus.arready = 1; #1;
    exp_q.push_back(32'h02800413);
    vec_cnt++; if (bus.arvalid !== 1'b1) begin err_cnt++; $display("FAIL ir_arvalid got=%0b exp=1", bus.arvalid); end
    vec_cnt++; if (bus.arid !== 4'd0) begin err_cnt++; $display("FAIL ir_arid got=%0d exp=0", bus.arid); end
    vec_cnt++; if (bus.arsize !== 3'b010) begin err_cnt++; $display("FAIL ir_arsize got=%b exp=010", bus.arsize); end
    vec_cnt++; if (bus.araddr !== 32'h1c000000) begin err_cnt++; $display("FAIL ir_araddr got=%h exp=1c000000", bus.araddr); end
    vec_cnt++; if ({bus.arlen, bus.arburst, bus.arlock, bus.arcache, bus.arprot} !== {8'd0, 2'b01, 2'b00, 4'd0, 3'd0}) begin err_cnt++; $display("FAIL ir_ar_consts got=%h exp=%h", {bus.arlen, bus.arburst, bus.arlock, bus.arcache, bus.arprot}, {8'd0, 2'b01, 2'b00, 4'd0, 3'd0}); end
    cyc(); bus.arready = 0; #1;
    vec_cnt++; if ({bus.arvalid, bus.rready, inst_sram_data_ok} !== 3'b010) begin err_cnt++; $display("FAIL ir_wait got=%b exp=010", {bus.arvalid, bus.rready, inst_sram_data_ok}); end
    cyc(); bus.rvalid = 1; bus.rdata = 32'h02800413; bus.rid = 4'd7; bus.rresp = 2'b10; #1;
    exp_v = exp_q.pop_front();
    vec_cnt++; if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b10) begin err_cnt++; $display("FAIL ir_data_ok got=%b exp=10", {inst_sram_data_ok, data_sram_data_ok}); end
    vec_cnt++; if (inst_sram_rdata !== exp_v) begin err_cnt++; $display("FAIL ir_rdata got=%h exp=%h", inst_sram_rdata, exp_v); end
    cyc(); bus.rvalid = 0; bus.rdata = 0; bus.rid = 0; bus.rresp = 0; #1;
    vec_cnt++; if ({inst_sram_data_ok, bus.rready} !== 2'b00) begin err_cnt++; $display("FAIL ir_after got=%b exp=00", {inst_sram_data_ok, bus.rready}); end
  endtask

  task automatic test_priority();
    cyc(); inst_sram_req = 1; inst_sram_addr = 32'h1c000010;
    data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h1c008000; #1;
    vec_cnt++; if ({data_sram_addr_ok, inst_sram_addr_ok} !== 2'b10) begin err_cnt++; $display("FAIL pr_addr_ok got=%b exp=10", {data_sram_addr_ok, inst_sram_addr_ok}); end
    cyc(); data_sram_req = 0; bus.arready = 1; #1;
    vec_cnt++; if ({bus.arvalid, bus.arid} !== {1'b1, 4'd1}) begin err_cnt++; $display("FAIL pr_arid_data got=%h exp=11", {bus.arvalid, bus.arid}); end
    vec_cnt++; if (bus.araddr !== 32'h1c008000) begin err_cnt++; $display("FAIL pr_araddr_data got=%h exp=1c008000", bus.araddr); end
    vec_cnt++; if (inst_sram_addr_ok !== 1'b0) begin err_cnt++; $display("FAIL pr_inst_blocked_ar got=%0b exp=0", inst_sram_addr_ok); end
    exp_q.push_back(32'hcafef00d);
    exp_q.push_back(32'h00000013);
    cyc(); bus.arready = 0; bus.rvalid = 1; bus.rdata = 32'hcafef00d; #1;
    exp_v = exp_q.pop_front();
    vec_cnt++; if ({data_sram_data_ok, inst_sram_data_ok, inst_sram_addr_ok} !== 3'b100) begin err_cnt++; $display("FAIL pr_data_ok got=%b exp=100", {data_sram_data_ok, inst_sram_data_ok, inst_sram_addr_ok}); end
    vec_cnt++; if (data_sram_rdata !== exp_v) begin err_cnt++; $display("FAIL pr_data_rdata got=%h exp=%h", data_sram_rdata, exp_v); end
    cyc(); bus.rvalid = 0; #1;
    vec_cnt++; if (inst_sram_addr_ok !== 1'b1) begin err_cnt++; $display("FAIL pr_inst_accept got=%0b exp=1", inst_sram_addr_ok); end
    cyc(); inst_sram_req = 0; bus.arready = 1; #1;
    vec_cnt++; if ({bus.arid, bus.araddr} !== {4'd0, 32'h1c000010}) begin err_cnt++; $display("FAIL pr_ar_inst got=%h exp=01c000010", {bus.arid, bus.araddr}); end
    cyc(); bus.arready = 0; bus.rvalid = 1; bus.rdata = 32'h00000013; #1;
    exp_v = exp_q.pop_front();
    vec_cnt++; if ({inst_sram_data_ok, inst_sram_rdata} !== {1'b1, exp_v}) begin err_cnt++; $display("FAIL pr_inst_resp got=%h exp=%h", {inst_sram_data_ok, inst_sram_rdata}, {1'b1, exp_v}); end
    cyc(); bus.rvalid = 0;
  endtask

  task automatic test_write_aw_delay();
    int aw_cnt, w_cnt, b_early;
    aw_cnt = 0; w_cnt = 0; b_early = 0;
    cyc(); data_write(32'h1c008000, 32'h12345678); #1;
    vec_cnt++; if (data_sram_addr_ok !== 1'b1) begin err_cnt++; $display("FAIL wr_addr_ok got=%0b exp=1", data_sram_addr_ok); end
    for (int i = 0; i < 4; i++) begin
      cyc(); data_sram_req = 0; data_sram_wr = 0; bus.wready = 1; bus.awready = (i == 3); #1;
      if (bus.awvalid === 1'b1) aw_cnt++;
      if (bus.wvalid === 1'b1) w_cnt++;
      if (bus.bready === 1'b1) b_early++;
      if (i == 0) begin
        vec_cnt++; if ({bus.awaddr, bus.wdata, bus.wstrb, bus.wlast, bus.awsize} !== {32'h1c008000, 32'h12345678, 4'hF, 1'b1, 3'b010}) begin err_cnt++; $display("FAIL wr_fields got=%h exp=%h", {bus.awaddr, bus.wdata, bus.wstrb, bus.wlast, bus.awsize}, {32'h1c008000, 32'h12345678, 4'hF, 1'b1, 3'b010}); end
        vec_cnt++; if ({bus.awid, bus.wid} !== {4'd1, 4'd1}) begin err_cnt++; $display("FAIL wr_ids got=%h exp=11", {bus.awid, bus.wid}); end
      end
    end
    vec_cnt++; if (aw_cnt !== 4) begin err_cnt++; $display("FAIL wr_awvalid_cycles got=%0d exp=4", aw_cnt); end
    vec_cnt++; if (w_cnt !== 1) begin err_cnt++; $display("FAIL wr_wvalid_cycles got=%0d exp=1", w_cnt); end
    vec_cnt++; if (b_early !== 0) begin err_cnt++; $display("FAIL wr_bready_early got=%0d exp=0", b_early); end
    cyc(); bus.awready = 0; bus.wready = 0; #1;
    vec_cnt++; if ({bus.awvalid, bus.bready, data_sram_data_ok} !== 3'b010) begin err_cnt++; $display("FAIL wr_b_wait got=%b exp=010", {bus.awvalid, bus.bready, data_sram_data_ok}); end
    cyc(); bus.bvalid = 1; bus.bresp = 2'b11; #1;
    vec_cnt++; if (data_sram_data_ok !== 1'b1) begin err_cnt++; $display("FAIL wr_data_ok got=%0b exp=1", data_sram_data_ok); end
    cyc(); bus.bvalid = 0; bus.bresp = 0; #1;
    vec_cnt++; if ({bus.bready, data_sram_data_ok, w_state_dbg} !== 4'b0000) begin err_cnt++; $display("FAIL wr_done got=%b exp=0000", {bus.bready, data_sram_data_ok, w_state_dbg}); end
  endtask

  task automatic test_hazard();
    cyc(); data_write(32'h00000100, 32'ha5a5a5a5); #1;
    vec_cnt++; if (data_sram_addr_ok !== 1'b1) begin err_cnt++; $display("FAIL hz_wr_accept got=%0b exp=1", data_sram_addr_ok); end
    cyc(); data_sram_req = 0; data_sram_wr = 0; inst_sram_req = 1; inst_sram_addr = 32'h00000104; #1;
    vec_cnt++; if (inst_sram_addr_ok !== 1'b1) begin err_cnt++; $display("FAIL hz_other_word got=%0b exp=1", inst_sram_addr_ok); end
    cyc(); inst_sram_req = 0; bus.arready = 1; #1;
    vec_cnt++; if ({bus.arvalid, bus.araddr} !== {1'b1, 32'h00000104}) begin err_cnt++; $display("FAIL hz_ar_104 got=%h exp=100000104", {bus.arvalid, bus.araddr}); end
    cyc(); bus.arready = 0; bus.rvalid = 1; bus.rdata = 32'h00000077; #1;
    vec_cnt++; if ({inst_sram_data_ok, inst_sram_rdata} !== {1'b1, 32'h00000077}) begin err_cnt++; $display("FAIL hz_resp_104 got=%h exp=100000077", {inst_sram_data_ok, inst_sram_rdata}); end
    cyc(); bus.rvalid = 0; inst_sram_req = 1; inst_sram_addr = 32'h00000100; #1;
    vec_cnt++; if (inst_sram_addr_ok !== 1'b0) begin err_cnt++; $display("FAIL hz_send_block got=%0b exp=0", inst_sram_addr_ok); end
    cyc(); bus.awready = 1; bus.wready = 1; #1;
    vec_cnt++; if (inst_sram_addr_ok !== 1'b0) begin err_cnt++; $display("FAIL hz_hs_block got=%0b exp=0", inst_sram_addr_ok); end
    cyc(); bus.awready = 0; bus.wready = 0; #1;
    vec_cnt++; if ({bus.bready, inst_sram_addr_ok} !== 2'b10) begin err_cnt++; $display("FAIL hz_b_block got=%b exp=10", {bus.bready, inst_sram_addr_ok}); end
    cyc(); bus.bvalid = 1; #1;
    vec_cnt++; if ({data_sram_data_ok, inst_sram_addr_ok} !== 2'b10) begin err_cnt++; $display("FAIL hz_bvalid got=%b exp=10", {data_sram_data_ok, inst_sram_addr_ok}); end
    cyc(); bus.bvalid = 0; #1;
    vec_cnt++; if (inst_sram_addr_ok !== 1'b1) begin err_cnt++; $display("FAIL hz_release got=%0b exp=1", inst_sram_addr_ok); end
    cyc(); inst_sram_req = 0; bus.arready = 1; #1;
    vec_cnt++; if (bus.araddr !== 32'h00000100) begin err_cnt++; $display("FAIL hz_ar_100 got=%h exp=00000100", bus.araddr); end
    cyc(); bus.arready = 0; bus.rvalid = 1; bus.rdata = 32'ha5a5a5a5; #1;
    vec_cnt++; if ({inst_sram_data_ok, inst_sram_rdata} !== {1'b1, 32'ha5a5a5a5}) begin err_cnt++; $display("FAIL hz_resp_100 got=%h exp=1a5a5a5a5", {inst_sram_data_ok, inst_sram_rdata}); end
    cyc(); bus.rvalid = 0;
  endtask

  task automatic test_back_to_back();
    cyc(); data_write(32'h00000200, 32'h00000005); #1;
    vec_cnt++; if (data_sram_addr_ok !== 1'b1) begin err_cnt++; $display("FAIL bb_wr_accept got=%0b exp=1", data_sram_addr_ok); end
    cyc(); data_sram_wr = 0; data_sram_addr = 32'h00000300; bus.awready = 1; bus.wready = 1; #1;
    vec_cnt++; if (data_sram_addr_ok !== 1'b0) begin err_cnt++; $display("FAIL bb_rd_block_send got=%0b exp=0", data_sram_addr_ok); end
    cyc(); bus.awready = 0; bus.wready = 0; #1;
    vec_cnt++; if ({bus.bready, data_sram_addr_ok} !== 2'b10) begin err_cnt++; $display("FAIL bb_rd_block_b got=%b exp=10", {bus.bready, data_sram_addr_ok}); end
    cyc(); bus.bvalid = 1; #1;
    vec_cnt++; if ({data_sram_data_ok, data_sram_addr_ok, bus.arvalid} !== 3'b100) begin err_cnt++; $display("FAIL bb_b_resp got=%b exp=100", {data_sram_data_ok, data_sram_addr_ok, bus.arvalid}); end
    cyc(); bus.bvalid = 0; #1;
    vec_cnt++; if (data_sram_addr_ok !== 1'b1) begin err_cnt++; $display("FAIL bb_rd_accept got=%0b exp=1", data_sram_addr_ok); end
    cyc(); data_sram_req = 0; bus.arready = 1; #1;
    vec_cnt++; if ({bus.arid, bus.araddr} !== {4'd1, 32'h00000300}) begin err_cnt++; $display("FAIL bb_ar got=%h exp=100000300", {bus.arid, bus.araddr}); end
    cyc(); bus.arready = 0; bus.rvalid = 1; bus.rdata = 32'h00003003; #1;
    vec_cnt++; if ({data_sram_data_ok, data_sram_rdata} !== {1'b1, 32'h00003003}) begin err_cnt++; $display("FAIL bb_rd_resp got=%h exp=100003003", {data_sram_data_ok, data_sram_rdata}); end
    cyc(); bus.rvalid = 0;
  endtask

  task automatic test_reset_in_flight();
    cyc(); inst_sram_req = 1; inst_sram_addr = 32'h1c000020; #1;
    vec_cnt++; if (inst_sram_addr_ok !== 1'b1) begin err_cnt++; $display("FAIL rf_accept got=%0b exp=1", inst_sram_addr_ok); end
    cyc(); inst_sram_req = 0; bus.arready = 1;
    cyc(); bus.arready = 0; #1;
    vec_cnt++; if (bus.rready !== 1'b1) begin err_cnt++; $display("FAIL rf_in_wait got=%0b exp=1", bus.rready); end
    cyc(); resetn = 0; #1;
    vec_cnt++; if ({bus.arvalid, bus.rready, r_state_dbg} !== 4'b0000) begin err_cnt++; $display("FAIL rf_drop got=%b exp=0000", {bus.arvalid, bus.rready, r_state_dbg}); end
    cyc(); resetn = 1;
    cyc(); bus.rvalid = 1; bus.rdata = 32'h00000099; #1;
    vec_cnt++; if ({inst_sram_data_ok, data_sram_data_ok, bus.rready} !== 3'b000) begin err_cnt++; $display("FAIL rf_stale_rvalid got=%b exp=000", {inst_sram_data_ok, data_sram_data_ok, bus.rready}); end
    cyc(); bus.rvalid = 0;
  endtask

  initial begin
    init_inputs();
    test_reset();
    test_inst_read();
    test_priority();
    test_write_aw_delay();
    test_hazard();
    test_back_to_back();
    test_reset_in_flight();
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
